// File: rtl/i2c_cmd_sequencer.sv
// i2c_cmd_sequencer: queues host read/write commands and issues them one
// at a time to the I2C EEPROM master. Watchdog: define I2C_SEQ_TIMEOUT_EN.
module i2c_cmd_sequencer #(
  parameter int DEPTH     = 4,
  parameter int NEWD_HOLD = 24,
  parameter int TIMEOUT   = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_wr,
  input  logic [6:0]             cmd_addr,
  input  logic [7:0]             cmd_wdata,
  output logic                   newd,
  output logic                   wr,
  output logic [6:0]             addr,
  output logic [7:0]             wdata,
  input  logic                   done,
  input  logic [7:0]             rdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_wr,
  output logic [7:0]             rsp_data,
  output logic                   rsp_err,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int HW = $clog2(NEWD_HOLD + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE
  } state_t;

  state_t        state;
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic [HW-1:0] hold;
  logic          done_q;
  logic          push;
  logic          pop;
  logic          done_rise;
  logic          timeout_hit;
  logic          finish;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
      NEWD_HOLD < 2 || TIMEOUT < 1) begin : g_bad_cfg
    $error("i2c_cmd_sequencer: illegal parameters");
  end

  assign cmd_ready  = (count != (AW+1)'(DEPTH));
  assign fifo_count = count;
  assign busy       = (state != IDLE);
  assign push       = cmd_valid && cmd_ready;
  assign pop        = (state == IDLE) && (count != '0) && !rsp_valid;
  assign done_rise  = done && !done_q;
  assign finish     = (state != IDLE) && (done_rise || timeout_hit);

`ifdef I2C_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wdog;

  assign timeout_hit = (state == WAIT_DONE) && !done_rise &&
                       (wdog == TW'(TIMEOUT - 1));

  // Watchdog counts cycles spent waiting for completion
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog    <= '0;
      rsp_err <= 1'b0;
    end else begin
      wdog <= (state == WAIT_DONE) ? wdog + TW'(1) : '0;
      if (finish) rsp_err <= timeout_hit;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign rsp_err     = 1'b0;
`endif

  // Queue storage; contents are don't-care until a push fills them
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {cmd_wr, cmd_addr, cmd_wdata};
  end

  // Queue pointers, occupancy and done edge history
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= done;
      if (push) wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      if (push && !pop) count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
    end
  end

  // Issue/complete sequencing with registered master and response outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      newd      <= 1'b0;
      wr        <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      hold      <= '0;
      rsp_valid <= 1'b0;
      rsp_wr    <= 1'b0;
      rsp_data  <= '0;
    end else begin
      if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
      if (finish) begin
        newd      <= 1'b0;
        rsp_valid <= 1'b1;
        rsp_wr    <= wr;
        rsp_data  <= (wr || timeout_hit) ? 8'h00 : rdata;
        state     <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (pop) begin
              {wr, addr, wdata} <= mem[rptr];
              newd  <= 1'b1;
              hold  <= HW'(NEWD_HOLD - 1);
              state <= ISSUE;
            end
          end
          ISSUE: begin
            if (hold == '0) begin
              newd  <= 1'b0;
              state <= WAIT_DONE;
            end else begin
              hold <= hold - HW'(1);
            end
          end
          WAIT_DONE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
